// File: rtl/tlb_pkg.sv
// Shared types and field layout for the software-managed TLB (tlb_array).
// Enabling TLB_KSEG_BYPASS_EN makes kseg0/kseg1 addresses bypass translation.
package tlb_pkg;

  localparam int VPN2_W      = 19;
  localparam int PFN_W       = 24;
  localparam int ASID_MAX_W  = 8;
  localparam int HI_VPN2_LSB = 13;
  localparam int LO_PFN_LSB  = 6;
  localparam int LO_D_BIT    = 2;
  localparam int LO_V_BIT    = 1;
  localparam int LO_G_BIT    = 0;

  typedef struct packed {
    logic [VPN2_W-1:0]     vpn2;
    logic [ASID_MAX_W-1:0] asid;
    logic                  g;
    logic [PFN_W-1:0]      pfn0;
    logic                  d0;
    logic                  v0;
    logic [PFN_W-1:0]      pfn1;
    logic                  d1;
    logic                  v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        miss;
    logic        invalid;
    logic        modified;
  } xlate_t;

  // Only the low 20 PFN bits reach the 32-bit physical address.
  function automatic logic [31:0] make_paddr(input logic [PFN_W-1:0] pfn, input logic [11:0] off);
    return (32'(pfn) << 12) | 32'(off);
  endfunction

  // Segment bits 2'b10 cover 0x8000_0000..0xBFFF_FFFF (kseg0 + kseg1).
  function automatic logic is_kseg(input logic [1:0] seg);
    return seg == 2'b10;
  endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Fully-associative match over all entries with lowest-index priority, plus
// even/odd page selection and address translation for one lookup port.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter  int NUM_ENTRIES = 16,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  tlb_entry_t [NUM_ENTRIES-1:0] entries,
  input  logic [31:0]                  vaddr,
  input  logic [ASID_MAX_W-1:0]        asid,
  input  logic                         we,
  output logic                         hit,
  output logic [IDX_W-1:0]             index,
  output tlb_entry_t                   entry,
  output xlate_t                       xl
);

  logic [PFN_W-1:0] pfn_s;
  logic             d_s;
  logic             v_s;

  // Priority match: scanning downward lets the lowest matching index win.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    entry = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].vpn2 == vaddr[31:HI_VPN2_LSB] &&
          (entries[i].g || entries[i].asid == asid)) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        entry = entries[i];
      end else begin
        hit = hit;
      end
    end
  end

  // Page select on vaddr[12] and translation of the matched entry.
  always_comb begin
    if (vaddr[12]) begin
      pfn_s = entry.pfn1;
      d_s   = entry.d1;
      v_s   = entry.v1;
    end else begin
      pfn_s = entry.pfn0;
      d_s   = entry.d0;
      v_s   = entry.v0;
    end
    xl = '0;
    if (hit) begin
      xl.paddr    = make_paddr(pfn_s, vaddr[11:0]);
      xl.invalid  = ~v_s;
      xl.modified = we & v_s & ~d_s;
    end else begin
      xl.miss = 1'b1;
    end
  end

endmodule

// File: rtl/tlb_array.sv
// MIPS-style joint TLB: tlbwi/tlbwr/tlbp/tlbr commands, random replacement
// index, and combinational inst/data translation. Macro: TLB_KSEG_BYPASS_EN.
module tlb_array
  import tlb_pkg::*;
#(
  parameter  int NUM_ENTRIES = 16,
  parameter  int ASID_W      = 8,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tlbwi,
  input  logic              tlbwr,
  input  logic              tlbp,
  input  logic              tlbr,
  input  logic [IDX_W-1:0]  cfg_index,
  input  logic [31:0]       cfg_entryhi,
  input  logic [31:0]       cfg_entrylo0,
  input  logic [31:0]       cfg_entrylo1,
  input  logic [IDX_W-1:0]  wired,
  input  logic [ASID_W-1:0] cur_asid,
  output logic [IDX_W-1:0]  random,
  output logic              probe_valid,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,
  output logic              rd_valid,
  output logic [31:0]       rd_entryhi,
  output logic [31:0]       rd_entrylo0,
  output logic [31:0]       rd_entrylo1,
  input  logic [31:0]       inst_vaddr,
  input  logic [31:0]       data_vaddr,
  input  logic              data_we,
  output logic [31:0]       inst_paddr,
  output logic [31:0]       data_paddr,
  output logic              inst_miss,
  output logic              inst_invalid,
  output logic              data_miss,
  output logic              data_invalid,
  output logic              data_modified
);

  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [ASID_MAX_W-1:0] ASID_MASK = ASID_MAX_W'((1 << ASID_W) - 1);

  tlb_entry_t [NUM_ENTRIES-1:0] entries_q, entries_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic [IDX_W-1:0] wired_q, wired_d;
  logic             probe_valid_q, probe_valid_d;
  logic             probe_hit_q, probe_hit_d;
  logic [IDX_W-1:0] probe_index_q, probe_index_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_entryhi_q, rd_entryhi_d;
  logic [31:0]      rd_entrylo0_q, rd_entrylo0_d;
  logic [31:0]      rd_entrylo1_q, rd_entrylo1_d;

  tlb_entry_t            new_entry_s;
  tlb_entry_t            rd_entry_s;
  logic [ASID_MAX_W-1:0] cur_asid_s;
  logic                  inst_hit_s, data_hit_s, probe_hit_s;
  logic [IDX_W-1:0]      inst_idx_s, data_idx_s, probe_idx_s;
  tlb_entry_t            inst_entry_s, data_entry_s, probe_entry_s;
  xlate_t                inst_xl_s, data_xl_s, probe_xl_s;
  logic                  unused_bits_s;

  // Pack the cfg_* registers into entry format; G is the AND of both lo words.
  always_comb begin
    new_entry_s      = '0;
    new_entry_s.vpn2 = cfg_entryhi[HI_VPN2_LSB +: VPN2_W];
    new_entry_s.asid = cfg_entryhi[ASID_MAX_W-1:0] & ASID_MASK;
    new_entry_s.g    = cfg_entrylo0[LO_G_BIT] & cfg_entrylo1[LO_G_BIT];
    new_entry_s.pfn0 = cfg_entrylo0[LO_PFN_LSB +: PFN_W];
    new_entry_s.d0   = cfg_entrylo0[LO_D_BIT];
    new_entry_s.v0   = cfg_entrylo0[LO_V_BIT];
    new_entry_s.pfn1 = cfg_entrylo1[LO_PFN_LSB +: PFN_W];
    new_entry_s.d1   = cfg_entrylo1[LO_D_BIT];
    new_entry_s.v1   = cfg_entrylo1[LO_V_BIT];
    cur_asid_s       = ASID_MAX_W'(cur_asid);
    rd_entry_s       = entries_q[cfg_index];
  end

  tlb_lookup #(.NUM_ENTRIES(NUM_ENTRIES)) u_inst_lookup (
    .entries(entries_q), .vaddr(inst_vaddr), .asid(cur_asid_s), .we(1'b0),
    .hit(inst_hit_s), .index(inst_idx_s), .entry(inst_entry_s), .xl(inst_xl_s)
  );

  tlb_lookup #(.NUM_ENTRIES(NUM_ENTRIES)) u_data_lookup (
    .entries(entries_q), .vaddr(data_vaddr), .asid(cur_asid_s), .we(data_we),
    .hit(data_hit_s), .index(data_idx_s), .entry(data_entry_s), .xl(data_xl_s)
  );

  // Probe reuses the lookup on pre-write contents; the page offset is irrelevant.
  tlb_lookup #(.NUM_ENTRIES(NUM_ENTRIES)) u_probe_lookup (
    .entries(entries_q), .vaddr({cfg_entryhi[31:HI_VPN2_LSB], 13'd0}),
    .asid(new_entry_s.asid), .we(1'b0),
    .hit(probe_hit_s), .index(probe_idx_s), .entry(probe_entry_s), .xl(probe_xl_s)
  );

  // Translation outputs, with optional unmapped-segment bypass.
  always_comb begin
    inst_paddr    = inst_xl_s.paddr;
    inst_miss     = inst_xl_s.miss;
    inst_invalid  = inst_xl_s.invalid;
    data_paddr    = data_xl_s.paddr;
    data_miss     = data_xl_s.miss;
    data_invalid  = data_xl_s.invalid;
    data_modified = data_xl_s.modified;
`ifdef TLB_KSEG_BYPASS_EN
    if (is_kseg(inst_vaddr[31:30])) begin
      inst_paddr   = inst_vaddr & 32'h1FFF_FFFF;
      inst_miss    = 1'b0;
      inst_invalid = 1'b0;
    end else begin
      inst_paddr = inst_xl_s.paddr;
    end
    if (is_kseg(data_vaddr[31:30])) begin
      data_paddr    = data_vaddr & 32'h1FFF_FFFF;
      data_miss     = 1'b0;
      data_invalid  = 1'b0;
      data_modified = 1'b0;
    end else begin
      data_paddr = data_xl_s.paddr;
    end
`endif
  end

  // Next-state: entry writes, random counter, probe and read result registers.
  always_comb begin
    entries_d = entries_q;
    if (tlbwi) begin
      entries_d[cfg_index] = new_entry_s;
    end else if (tlbwr) begin
      entries_d[random_q] = new_entry_s;
    end else begin
      entries_d = entries_q;
    end

    wired_d = wired;
    if (wired != wired_q) begin
      random_d = IDX_MAX;
    end else if (wired == IDX_MAX) begin
      random_d = IDX_MAX;
    end else if (random_q == wired || random_q == '0) begin
      random_d = IDX_MAX;
    end else begin
      random_d = random_q - IDX_W'(1);
    end

    probe_valid_d = tlbp;
    if (tlbp) begin
      probe_hit_d   = probe_hit_s;
      probe_index_d = probe_hit_s ? probe_idx_s : '0;
    end else begin
      probe_hit_d   = probe_hit_q;
      probe_index_d = probe_index_q;
    end

    rd_valid_d = tlbr;
    if (tlbr) begin
      rd_entryhi_d  = {rd_entry_s.vpn2, 5'd0, rd_entry_s.asid};
      rd_entrylo0_d = {2'd0, rd_entry_s.pfn0, 3'd0, rd_entry_s.d0, rd_entry_s.v0, rd_entry_s.g};
      rd_entrylo1_d = {2'd0, rd_entry_s.pfn1, 3'd0, rd_entry_s.d1, rd_entry_s.v1, rd_entry_s.g};
    end else begin
      rd_entryhi_d  = rd_entryhi_q;
      rd_entrylo0_d = rd_entrylo0_q;
      rd_entrylo1_d = rd_entrylo1_q;
    end
  end

  // State registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q     <= '0;
      random_q      <= IDX_MAX;
      wired_q       <= '0;
      probe_valid_q <= 1'b0;
      probe_hit_q   <= 1'b0;
      probe_index_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_entryhi_q  <= 32'd0;
      rd_entrylo0_q <= 32'd0;
      rd_entrylo1_q <= 32'd0;
    end else begin
      entries_q     <= entries_d;
      random_q      <= random_d;
      wired_q       <= wired_d;
      probe_valid_q <= probe_valid_d;
      probe_hit_q   <= probe_hit_d;
      probe_index_q <= probe_index_d;
      rd_valid_q    <= rd_valid_d;
      rd_entryhi_q  <= rd_entryhi_d;
      rd_entrylo0_q <= rd_entrylo0_d;
      rd_entrylo1_q <= rd_entrylo1_d;
    end
  end

  assign random      = random_q;
  assign probe_valid = probe_valid_q;
  assign probe_hit   = probe_hit_q;
  assign probe_index = probe_index_q;
  assign rd_valid    = rd_valid_q;
  assign rd_entryhi  = rd_entryhi_q;
  assign rd_entrylo0 = rd_entrylo0_q;
  assign rd_entrylo1 = rd_entrylo1_q;

  assign unused_bits_s = ^{cfg_entryhi[12:8], cfg_entrylo0[31:30], cfg_entrylo0[5:3],
                           cfg_entrylo1[31:30], cfg_entrylo1[5:3], inst_hit_s, inst_idx_s,
                           inst_entry_s, inst_xl_s.modified, data_hit_s, data_idx_s,
                           data_entry_s, probe_entry_s, probe_xl_s};

endmodule

// File: tb/tb_tlb_array.sv
// Directed self-checking bench for tlb_array (16 entries, 8-bit ASID).
module tb_tlb_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        tlbwi, tlbwr, tlbp, tlbr;
  logic [3:0]  cfg_index;
  logic [31:0] cfg_entryhi, cfg_entrylo0, cfg_entrylo1;
  logic [3:0]  wired;
  logic [7:0]  cur_asid;
  logic [3:0]  random;
  logic        probe_valid, probe_hit;
  logic [3:0]  probe_index;
  logic        rd_valid;
  logic [31:0] rd_entryhi, rd_entrylo0, rd_entrylo1;
  logic [31:0] inst_vaddr, data_vaddr;
  logic        data_we;
  logic [31:0] inst_paddr, data_paddr;
  logic        inst_miss, inst_invalid, data_miss, data_invalid, data_modified;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlb_array #(.NUM_ENTRIES(16), .ASID_W(8)) dut (
    .clk(clk), .rst(rst), .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .tlbr(tlbr),
    .cfg_index(cfg_index), .cfg_entryhi(cfg_entryhi), .cfg_entrylo0(cfg_entrylo0),
    .cfg_entrylo1(cfg_entrylo1), .wired(wired), .cur_asid(cur_asid), .random(random),
    .probe_valid(probe_valid), .probe_hit(probe_hit), .probe_index(probe_index),
    .rd_valid(rd_valid), .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0),
    .rd_entrylo1(rd_entrylo1), .inst_vaddr(inst_vaddr), .data_vaddr(data_vaddr),
    .data_we(data_we), .inst_paddr(inst_paddr), .data_paddr(data_paddr),
    .inst_miss(inst_miss), .inst_invalid(inst_invalid), .data_miss(data_miss),
    .data_invalid(data_invalid), .data_modified(data_modified)
  );

  task automatic cmd_write(input logic [3:0] idx, input logic [31:0] hi, input logic [31:0] lo0,
                           input logic [31:0] lo1);
    @(negedge clk);
    cfg_index = idx; cfg_entryhi = hi; cfg_entrylo0 = lo0; cfg_entrylo1 = lo1; tlbwi = 1'b1;
    @(negedge clk);
    tlbwi = 1'b0;
  endtask

  task automatic cmd_read(input logic [3:0] idx);
    @(negedge clk);
    cfg_index = idx; tlbr = 1'b1;
    @(negedge clk);
    tlbr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (inst_miss !== 1'b1) begin n_fail++; $display("FAIL rst_inst_miss: got %b expected 1", inst_miss); end
    n_checks++; if (inst_paddr !== 32'h0) begin n_fail++; $display("FAIL rst_inst_paddr: got %h expected 0", inst_paddr); end
    n_checks++; if (data_miss !== 1'b1) begin n_fail++; $display("FAIL rst_data_miss: got %b expected 1", data_miss); end
    n_checks++; if (random !== 4'd15) begin n_fail++; $display("FAIL rst_random: got %0d expected 15", random); end
    n_checks++; if ({probe_valid, probe_hit, probe_index} !== 6'd0) begin n_fail++; $display("FAIL rst_probe: got %b%b%h expected 0", probe_valid, probe_hit, probe_index); end
    n_checks++; if ({rd_valid, rd_entryhi} !== 33'd0) begin n_fail++; $display("FAIL rst_rd: got %b %h expected 0", rd_valid, rd_entryhi); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_probe_empty();
    @(negedge clk);
    cfg_entryhi = 32'h0040_0005; tlbp = 1'b1;
    @(negedge clk);
    tlbp = 1'b0;
    n_checks++; if (probe_valid !== 1'b1) begin n_fail++; $display("FAIL probe_empty_valid: got %b expected 1", probe_valid); end
    n_checks++; if (probe_hit !== 1'b0 || probe_index !== 4'd0) begin n_fail++; $display("FAIL probe_empty_result: got hit %b idx %0d expected 0 0", probe_hit, probe_index); end
    @(negedge clk);
    n_checks++; if (probe_valid !== 1'b0) begin n_fail++; $display("FAIL probe_pulse: got %b expected 0", probe_valid); end
  endtask

  task automatic test_translate();
    cur_asid = 8'd5;
    cmd_write(4'd3, 32'h0040_0005, 32'h0000_0482, 32'h0);
    data_vaddr = 32'h0040_0ABC; inst_vaddr = 32'h0040_0ABC; data_we = 1'b0;
    #1;
    n_checks++; if (data_paddr !== 32'h0001_2ABC) begin n_fail++; $display("FAIL xlate_data_paddr: got %h expected 00012abc", data_paddr); end
    n_checks++; if ({data_miss, data_invalid, data_modified} !== 3'b000) begin n_fail++; $display("FAIL xlate_data_flags: got %b expected 000", {data_miss, data_invalid, data_modified}); end
    n_checks++; if (inst_paddr !== 32'h0001_2ABC || inst_miss !== 1'b0) begin n_fail++; $display("FAIL xlate_inst: got %h miss %b expected 00012abc 0", inst_paddr, inst_miss); end
    data_we = 1'b1;
    #1;
    n_checks++; if (data_modified !== 1'b1) begin n_fail++; $display("FAIL xlate_modified: got %b expected 1", data_modified); end
    data_we = 1'b0;
  endtask

  task automatic test_asid_global();
    cur_asid = 8'd6;
    #1;
    n_checks++; if (data_miss !== 1'b1 || data_paddr !== 32'h0) begin n_fail++; $display("FAIL asid_miss: got %b %h expected 1 0", data_miss, data_paddr); end
    cmd_write(4'd3, 32'h0040_0005, 32'h0000_0483, 32'h0000_0001);
    #1;
    n_checks++; if (data_miss !== 1'b0 || data_paddr !== 32'h0001_2ABC) begin n_fail++; $display("FAIL global_hit: got %b %h expected 0 00012abc", data_miss, data_paddr); end
    data_vaddr = 32'h0040_1000; data_we = 1'b1;
    #1;
    n_checks++; if ({data_miss, data_invalid, data_modified} !== 3'b010) begin n_fail++; $display("FAIL odd_invalid: got %b expected 010", {data_miss, data_invalid, data_modified}); end
    data_we = 1'b0;
  endtask

  task automatic test_read();
    cmd_read(4'd3);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b expected 1", rd_valid); end
    n_checks++; if (rd_entryhi !== 32'h0040_0005) begin n_fail++; $display("FAIL rd_entryhi: got %h expected 00400005", rd_entryhi); end
    n_checks++; if (rd_entrylo0 !== 32'h0000_0483 || rd_entrylo1 !== 32'h0000_0001) begin n_fail++; $display("FAIL rd_entrylo: got %h %h expected 00000483 00000001", rd_entrylo0, rd_entrylo1); end
    @(negedge clk);
    n_checks++; if (rd_valid !== 1'b0 || rd_entryhi !== 32'h0040_0005) begin n_fail++; $display("FAIL rd_hold: got %b %h expected 0 00400005", rd_valid, rd_entryhi); end
  endtask

  task automatic test_lowest_and_probe();
    cur_asid = 8'd5;
    cmd_write(4'd9, 32'h1234_6005, 32'h0000_2642, 32'h0);
    cmd_write(4'd2, 32'h1234_6005, 32'h0000_0882, 32'h0);
    data_vaddr = 32'h1234_6010;
    #1;
    n_checks++; if (data_paddr !== 32'h0002_2010) begin n_fail++; $display("FAIL lowest_lookup: got %h expected 00022010", data_paddr); end
    @(negedge clk);
    cfg_entryhi = 32'h1234_6005; tlbp = 1'b1;
    @(negedge clk);
    tlbp = 1'b0;
    n_checks++; if (probe_hit !== 1'b1 || probe_index !== 4'd2) begin n_fail++; $display("FAIL probe_lowest: got hit %b idx %0d expected 1 2", probe_hit, probe_index); end
    // Write the same VPN2 into index 1 while probing: result must reflect old contents.
    cfg_index = 4'd1; cfg_entrylo0 = 32'h0000_0442; cfg_entrylo1 = 32'h0; tlbwi = 1'b1; tlbp = 1'b1;
    @(negedge clk);
    tlbwi = 1'b0; tlbp = 1'b0;
    n_checks++; if (probe_valid !== 1'b1 || probe_index !== 4'd2) begin n_fail++; $display("FAIL probe_prewrite: got valid %b idx %0d expected 1 2", probe_valid, probe_index); end
    #1;
    n_checks++; if (data_paddr !== 32'h0001_1010) begin n_fail++; $display("FAIL lookup_after_write: got %h expected 00011010", data_paddr); end
    @(negedge clk);
    tlbp = 1'b1;
    @(negedge clk);
    tlbp = 1'b0;
    n_checks++; if (probe_hit !== 1'b1 || probe_index !== 4'd1) begin n_fail++; $display("FAIL probe_postwrite: got hit %b idx %0d expected 1 1", probe_hit, probe_index); end
  endtask

  task automatic test_random();
    logic [3:0] exp_r;
    @(negedge clk);
    wired = 4'd4;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      exp_r = (k == 12) ? 4'd15 : 4'(15 - k);
      n_checks++; if (random !== exp_r) begin n_fail++; $display("FAIL random_seq_%0d: got %0d expected %0d", k, random, exp_r); end
    end
    wired = 4'd2;
    @(negedge clk);
    n_checks++; if (random !== 4'd15) begin n_fail++; $display("FAIL random_wired_change: got %0d expected 15", random); end
    cfg_entryhi = 32'h7000_0005; cfg_entrylo0 = 32'h0000_0482; cfg_entrylo1 = 32'h0; tlbwr = 1'b1;
    @(negedge clk);
    n_checks++; if (random !== 4'd14) begin n_fail++; $display("FAIL random_after_wr: got %0d expected 14", random); end
    cfg_index = 4'd5; cfg_entryhi = 32'h6000_0005; tlbwi = 1'b1;
    @(negedge clk);
    tlbwi = 1'b0; tlbwr = 1'b0;
    cmd_read(4'd15);
    n_checks++; if (rd_entryhi !== 32'h7000_0005) begin n_fail++; $display("FAIL tlbwr_target: got %h expected 70000005", rd_entryhi); end
    cmd_read(4'd14);
    n_checks++; if (rd_entryhi !== 32'h0) begin n_fail++; $display("FAIL wi_wr_no_random_write: got %h expected 0", rd_entryhi); end
    cmd_read(4'd5);
    n_checks++; if (rd_entryhi !== 32'h6000_0005) begin n_fail++; $display("FAIL wi_wr_indexed: got %h expected 60000005", rd_entryhi); end
  endtask

  task automatic test_bypass();
    data_vaddr = 32'h8001_2345; data_we = 1'b1;
    #1;
`ifdef TLB_KSEG_BYPASS_EN
    n_checks++; if (data_paddr !== 32'h0001_2345 || data_miss !== 1'b0 || data_modified !== 1'b0) begin n_fail++; $display("FAIL kseg_bypass: got %h miss %b expected 00012345 0", data_paddr, data_miss); end
`else
    n_checks++; if (data_paddr !== 32'h0 || data_miss !== 1'b1) begin n_fail++; $display("FAIL kseg_mapped: got %h miss %b expected 0 1", data_paddr, data_miss); end
`endif
    data_we = 1'b0;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    cfg_index = 4'd7; cfg_entryhi = 32'h0ABC_0005; cfg_entrylo0 = 32'h0000_0482;
    tlbwi = 1'b1; tlbp = 1'b1; tlbr = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (random !== 4'd15 || probe_hit !== 1'b0 || rd_entryhi !== 32'h0) begin n_fail++; $display("FAIL reset_clear: got r %0d hit %b hi %h expected 15 0 0", random, probe_hit, rd_entryhi); end
    @(negedge clk);
    tlbwi = 1'b0; tlbp = 1'b0; tlbr = 1'b0; rst = 1'b0;
    n_checks++; if (probe_valid !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_pulse: got %b %b expected 0 0", probe_valid, rd_valid); end
    cmd_read(4'd7);
    n_checks++; if (rd_entryhi !== 32'h0 || rd_entrylo0 !== 32'h0) begin n_fail++; $display("FAIL reset_no_write: got %h %h expected 0 0", rd_entryhi, rd_entrylo0); end
    data_vaddr = 32'h0040_0ABC; cur_asid = 8'd5;
    #1;
    n_checks++; if (data_miss !== 1'b1) begin n_fail++; $display("FAIL reset_entries_cleared: got %b expected 1", data_miss); end
  endtask

  initial begin
    rst = 1'b1;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbp = 1'b0; tlbr = 1'b0;
    cfg_index = 4'd0; cfg_entryhi = 32'h0; cfg_entrylo0 = 32'h0; cfg_entrylo1 = 32'h0;
    wired = 4'd0; cur_asid = 8'd0; data_we = 1'b0;
    inst_vaddr = 32'h0040_0000; data_vaddr = 32'h0040_0000;
    test_reset();
    test_probe_empty();
    test_translate();
    test_asid_global();
    test_read();
    test_lowest_and_probe();
    test_random();
    test_bypass();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
